// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// A start/done handshake lets a controller issue back-to-back operations.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_fin;

    // Single full-subtractor cell
    assign w_a0       = r_a_sr[0];
    assign w_b0       = r_b_sr[0];
    assign w_d        = w_a0 ^ w_b0 ^ r_br;
    assign w_br_nxt   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_diff_fin = {w_d, r_d_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= A;
                        r_b_sr   <= B;
                        r_br     <= Bin;
                        r_d_sr   <= '0;
                        r_cnt    <= '0;
                        r_sign_a <= A[WIDTH-1];
                        r_sign_b <= B[WIDTH-1];
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_d_sr <= w_diff_fin;
                    r_br   <= w_br_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff  <= w_diff_fin;
                        r_bout  <= w_br_nxt;
                        r_ovf   <= (r_sign_a != r_sign_b) && (w_diff_fin[WIDTH-1] != r_sign_a);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    int unsigned n_vec;
    int unsigned n_bad;
    logic [7:0]  prev_diff;
    logic        prev_bout;
    logic        prev_ovf;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .Ovf   (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present operands, let E0 accept them, then scramble the inputs.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        chk("accept_busy", busy, 1'b1);
        chk("accept_done", done, 1'b0);
    endtask

    // Walk E1..E8; optionally pulse start with new operands during RUN.
    task automatic finish_op(input string tag, input logic [7:0] ed, input logic eb,
                             input logic eo, input bit inject);
        for (int unsigned k = 1; k < WIDTH; k++) begin
            @(posedge clk); #1;
            chk({tag, "_run_busy"}, busy, 1'b1);
            chk({tag, "_run_done"}, done, 1'b0);
            chk({tag, "_hold_diff"}, Diff, prev_diff);
            chk({tag, "_hold_flags"}, {Bout, Ovf}, {prev_bout, prev_ovf});
            if (inject && k == 3) begin
                start = 1'b1; A = 8'hFF; B = 8'hFF; Bin = 1'b1;
            end
            if (inject && k == 4) start = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_diff"}, Diff, ed);
        chk({tag, "_bout"}, Bout, eb);
        chk({tag, "_ovf"}, Ovf, eo);
        prev_diff = ed; prev_bout = eb; prev_ovf = eo;
    endtask

    task automatic idle_after(input string tag);
        repeat (2) begin
            @(posedge clk); #1;
            chk({tag, "_single_done"}, done, 1'b0);
            chk({tag, "_idle_busy"}, busy, 1'b0);
            chk({tag, "_idle_diff"}, Diff, prev_diff);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_outs", {Diff, Bout, Ovf}, 10'h000);
        @(negedge clk); rst_n = 1'b1;
        idle_after("idle0");

        launch(8'h05, 8'h03, 1'b0); finish_op("v05_03", 8'h02, 1'b0, 1'b0, 1'b0); idle_after("v05_03");
        launch(8'h03, 8'h05, 1'b0); finish_op("v03_05", 8'hFE, 1'b1, 1'b0, 1'b0); idle_after("v03_05");
        launch(8'h00, 8'h00, 1'b1); finish_op("v00_bin", 8'hFF, 1'b1, 1'b0, 1'b0); idle_after("v00_bin");
        launch(8'h80, 8'h01, 1'b0); finish_op("v80_01", 8'h7F, 1'b0, 1'b1, 1'b0); idle_after("v80_01");
        launch(8'h7F, 8'hFF, 1'b0); finish_op("v7F_FF", 8'h80, 1'b1, 1'b1, 1'b0); idle_after("v7F_FF");

        // start during RUN must be ignored
        launch(8'h10, 8'h01, 1'b0); finish_op("ign", 8'h0F, 1'b0, 1'b0, 1'b1); idle_after("ign");

        // back-to-back: second start lands in the done cycle
        launch(8'h50, 8'h20, 1'b0); finish_op("b2b1", 8'h30, 1'b0, 1'b0, 1'b0);
        launch(8'h20, 8'h10, 1'b0); finish_op("b2b2", 8'h10, 1'b0, 1'b0, 1'b0); idle_after("b2b2");

        // asynchronous reset in the middle of cycle 4 of RUN
        launch(8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_outs", {Diff, Bout, Ovf}, 10'h000);
        prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
        repeat (WIDTH) begin
            @(posedge clk); #1;
            chk("arst_no_done", done, 1'b0);
        end
        @(negedge clk); rst_n = 1'b1;
        idle_after("post_rst");
        launch(8'h09, 8'h04, 1'b0); finish_op("v09_04", 8'h05, 1'b0, 1'b0, 1'b0); idle_after("v09_04");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
